arb_req_tracker: RTL
====================

# arb_req_tracker

Per-requester pending-transaction tracker that sits directly upstream of the round-robin arbiter. Each requester pulses `push` once per transaction. The block keeps a saturating pending count per channel and drives the arbiter's `req` vector from those counts. It consumes the arbiter's registered one-hot `grant` to retire transactions, and re-times each grant as an encoded index for the downstream datapath.

## Interface
- `N`, 4, number of requester channels; legal range 2..32.
- `CW`, 3, pending-counter width per channel; maximum pending count is 2^CW-1.
- `IW`, `$clog2(N)`, width of `gnt_idx`; localparam, minimum 1.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `push` in N: per-channel single-cycle transaction enqueue strobe.
- `full` out N: channel count equals 2^CW-1.
- `req` out N: to arbiter; bit i = (count[i] != 0).
- `grant` in N: from arbiter; registered, expected one-hot or zero.
- `gnt_vld` out 1: registered; a grant was retired last cycle.
- `gnt_idx` out IW: registered; index of the retired grant (lowest set bit).
- `pend_any` out 1: OR of all `req` bits.
- `err_ovf` out N: sticky; push dropped because the channel was full.
- `err_unf` out N: sticky; grant arrived on a channel with count 0.
- `err_multi` out 1: sticky; `grant` had more than one bit set.

## Operation
- State: N counters of CW bits, `gnt_vld`/`gnt_idx` registers, and the error registers.
- Per-channel update each cycle:
  - push only: count+1.
  - grant only: count-1.
  - push and grant together: count unchanged.
  - neither: hold.
- Saturation:
  - Push at count 2^CW-1 with no grant on that channel: push is dropped, count holds, `err_ovf[i]` is set.
  - Push and grant together on a full channel: both are accepted, count holds, no error.
- Underflow: grant at count 0 with no push holds count at 0 and sets `err_unf[i]`. Grant and push together at count 0 leave the count at 0 with no error (the push is retired immediately).
- Multi-bit grant: every asserted bit is retired independently. `err_multi` is set. `gnt_idx` reports the lowest set bit.
- `req`, `full` and `pend_any` are combinational from the counter registers only. There is no combinational path from `push` or `grant` to any output.
- Decoding: `gnt_vld <= |grant`. `gnt_idx <= lowest set index of grant`. When `grant` is zero, `gnt_idx` holds its value.
- Error bits stay set until `rst`. There is no other clear.

## Timing
- Reset values: all counters 0. `req`, `full`, `pend_any`, `gnt_vld`, `err_*` are 0. `gnt_idx` is 0.
- `rst` asserted mid-operation clears everything on the next edge. Pushes and grants presented during that cycle are discarded.
- Push-to-req latency: push at edge k is reflected in `req` after edge k (available for the arbiter's sample at edge k+1).
- Grant-to-retire latency: grant visible in cycle k decrements the count at edge k+1. `req[i]` falls in cycle k+1 if the count reaches 0. `gnt_vld`/`gnt_idx` are valid in cycle k+1.
- Because the arbiter never re-grants a bit it is currently granting, `req` staying high during the grant cycle causes no double retire.
- Back-to-back pushes on one channel accumulate one per cycle up to saturation.

## Configuration
- `ARB_REQ_TRACKER_ERR_EN`:
  - Defined: the `err_ovf`, `err_unf` and `err_multi` registers and their logic are built as described above.
  - Undefined: the ports remain but are tied to 0, and their registers are removed.
  - Counter saturation and underflow-hold behaviour is identical in both builds.

## Test plan
- Reset, then push ch0 ×3 in consecutive cycles → count0=3, `req`=0001. Then grant=0001 for 1 cycle → next cycle count0=2, `gnt_vld`=1, `gnt_idx`=0.
- N=4, CW=3: push ch2 ×9 back-to-back → count saturates at 7, `full[2]`=1 from the 7th push onward, `err_ovf[2]`=1 after the 8th push.
- Count1=1 with push1 and grant=0010 in the same cycle → count1 stays 1, `req[1]` stays 1, no error, `gnt_vld`=1 with `gnt_idx`=1.
- grant=1000 while count3=0 → count3 stays 0, `err_unf[3]`=1 (0 when the macro is undefined).
- grant=0110 → count1 and count2 each decrement by 1, `err_multi`=1, `gnt_idx`=1.
- With counts {2,1,3,1}, assert `rst` for one cycle → next cycle all counts 0, `req`=0000, `pend_any`=0, all `err_*`=0.

Source files
------------

// File: rtl/arb_req_tracker_if.sv
// Bundle between the requesters/arbiter and arb_req_tracker.
// master = requester/arbiter side, slave = tracker side.
interface arb_req_tracker_if #(
  parameter int N = 4
) ();
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  push;
  logic [N-1:0]  full;
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic          gnt_vld;
  logic [IW-1:0] gnt_idx;
  logic          pend_any;
  logic [N-1:0]  err_ovf;
  logic [N-1:0]  err_unf;
  logic          err_multi;

  modport master (
    output push, grant,
    input  full, req, gnt_vld, gnt_idx, pend_any, err_ovf, err_unf, err_multi
  );

  modport slave (
    input  push, grant,
    output full, req, gnt_vld, gnt_idx, pend_any, err_ovf, err_unf, err_multi
  );
endinterface

// File: rtl/arb_req_tracker.sv
// Per-channel saturating pending counters feeding a round-robin arbiter's req vector.
// Define ARB_REQ_TRACKER_ERR_EN to build the sticky overflow/underflow/multi-grant flags.
module arb_req_tracker #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic              clk,
  input  logic              rst,
  arb_req_tracker_if.slave  bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [N-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]         full_w, req_w;
  logic                 gnt_vld_q, gnt_vld_d;
  logic [IW-1:0]        gnt_idx_q, gnt_idx_d;
  logic [IW-1:0]        idx_lo;

  // Push and grant on the same channel cancel, which also covers the full and empty corners.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < N; i++) begin
      if (bus.push[i] && !bus.grant[i]) begin
        if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (!bus.push[i] && bus.grant[i]) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    assign full_w[gi] = (cnt_q[gi] == CNT_MAX);
    assign req_w[gi]  = (cnt_q[gi] != '0);
  end

  always_comb begin
    idx_lo = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.grant[i]) idx_lo = IW'(i);
    end
  end

  always_comb begin
    gnt_vld_d = |bus.grant;
    gnt_idx_d = gnt_idx_q;
    if (|bus.grant) gnt_idx_d = idx_lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      gnt_idx_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

  assign bus.full     = full_w;
  assign bus.req      = req_w;
  assign bus.pend_any = |req_w;
  assign bus.gnt_vld  = gnt_vld_q;
  assign bus.gnt_idx  = gnt_idx_q;

`ifdef ARB_REQ_TRACKER_ERR_EN
  logic [N-1:0] err_ovf_q, err_unf_q;
  logic         err_multi_q;
  logic         multi_w;

  assign multi_w = |(bus.grant & (bus.grant - N'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf_q   <= '0;
      err_unf_q   <= '0;
      err_multi_q <= 1'b0;
    end else begin
      err_ovf_q   <= err_ovf_q | (bus.push & ~bus.grant & full_w);
      err_unf_q   <= err_unf_q | (bus.grant & ~bus.push & ~req_w);
      err_multi_q <= err_multi_q | multi_w;
    end
  end

  assign bus.err_ovf   = err_ovf_q;
  assign bus.err_unf   = err_unf_q;
  assign bus.err_multi = err_multi_q;
`else
  assign bus.err_ovf   = '0;
  assign bus.err_unf   = '0;
  assign bus.err_multi = 1'b0;
`endif
endmodule
